// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helper
// for the round-robin bus arbiter.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam int BEAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_BURST = 2'd2
  } arb_state_e;

  // Zero marks an unbounded (INCR) burst.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:               burst_beats = 5'd1;
      HBURST_INCR:                 burst_beats = 5'd0;
      HBURST_WRAP4, HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  burst_beats = 5'd8;
      default:                     burst_beats = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating-priority picker: search starts one past the last owner
// and wraps, so the last owner is always lowest priority.
module ahb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam int PW = IW + 1;

  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = last_i;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= N; i++) begin
      pos = {1'b0, last_i} + PW'(i);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!found && req_i[pos[IW-1:0]]) begin
        found               = 1'b1;
        gnt_o[pos[IW-1:0]]  = 1'b1;
        idx_o               = pos[IW-1:0];
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with fixed-burst hold and INCR hold.
// Define AHB_ARB_LOCK_EN to honour HLOCK and drive HMASTLOCK.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int MASTER_NUM     = 4,
  parameter int HBURST_WIDTH   = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                          HCLK,
  input  logic                          HRST,
  input  logic [MASTER_NUM-1:0]         HBUSREQ,
  input  logic [MASTER_NUM-1:0]         HLOCK,
  input  logic [1:0]                    HTRANS,
  input  logic [HBURST_WIDTH-1:0]       HBURST,
  input  logic                          HREADY,
  output logic [MASTER_NUM-1:0]         HGRANT,
  output logic [$clog2(MASTER_NUM)-1:0] HMASTER,
  output logic                          HMASTLOCK
);

  localparam int IW = $clog2(MASTER_NUM);
  localparam logic [IW-1:0] DEF_IDX =
    IW'(DEFAULT_MASTER);
  localparam logic [MASTER_NUM-1:0] DEF_GNT =
    MASTER_NUM'(1) << DEFAULT_MASTER;

  arb_state_e            state_q, state_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [IW-1:0]         mast_q, mast_d;
  logic                  lock_q, lock_d;
  logic                  incr_q, incr_d;

  logic [4:0]            beats;
  logic                  accept;
  logic                  nonseq;
  logic                  in_burst;
  logic                  start_burst;
  logic                  last_beat;
  logic                  decide;
  logic                  owner_req;
  logic                  incr_raw;
  logic                  keep;
  logic                  lock_hold;
  logic [MASTER_NUM-1:0] lock_vec;

  logic [MASTER_NUM-1:0] pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

`ifdef AHB_ARB_LOCK_EN
  assign lock_vec  = HLOCK;
  assign lock_hold = HLOCK[mast_q] | lock_q;
`else
  logic lock_unused;
  assign lock_unused = ^HLOCK;
  assign lock_vec    = '0;
  assign lock_hold   = 1'b0;
`endif

  ahb_rr_picker #(
    .N  (MASTER_NUM),
    .IW (IW)
  ) u_picker (
    .req_i  (HBUSREQ),
    .last_i (mast_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign beats     = burst_beats(3'(HBURST));
  assign nonseq    = HTRANS == HTRANS_NONSEQ;
  assign accept    = HREADY &&
                     (nonseq || HTRANS == HTRANS_SEQ);
  assign in_burst  = state_q == ARB_BURST;
  assign owner_req = HBUSREQ[mast_q];

  assign start_burst = !in_burst && accept &&
                       nonseq && beats > 5'd1;
  assign last_beat   = in_burst && accept &&
                       cnt_q <= BEAT_CNT_W'(1);
  assign decide      = (HREADY && !in_burst && !start_burst) ||
                       last_beat;

  // An INCR owner holds the bus until it goes IDLE or drops HBUSREQ.
  always_comb begin
    incr_raw = incr_q;
    if (in_burst) begin
      incr_raw = 1'b0;
    end else if (HREADY && nonseq) begin
      incr_raw = 3'(HBURST) == HBURST_INCR;
    end else if (HREADY && HTRANS == HTRANS_IDLE) begin
      incr_raw = 1'b0;
    end
  end

  assign incr_d = incr_raw && owner_req;
  assign keep   = incr_d || lock_hold;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    mast_d  = mast_q;
    lock_d  = lock_q;

    if (start_burst) begin
      state_d = ARB_BURST;
      cnt_d   = BEAT_CNT_W'(beats - 5'd1);
    end else if (last_beat) begin
      cnt_d   = '0;
    end else if (in_burst && accept) begin
      cnt_d   = cnt_q - BEAT_CNT_W'(1);
    end else if (in_burst && HREADY &&
                 HTRANS == HTRANS_IDLE) begin
      state_d = ARB_OWN;
      cnt_d   = '0;
    end

    if (decide) begin
      if (keep) begin
        state_d = ARB_OWN;
      end else if (pick_any) begin
        state_d = ARB_OWN;
        grant_d = pick_gnt;
        mast_d  = pick_idx;
      end else begin
        state_d = ARB_IDLE;
        grant_d = DEF_GNT;
        mast_d  = DEF_IDX;
      end
      lock_d = lock_vec[mast_d];
    end
  end

  always_ff @(posedge HCLK or negedge HRST) begin
    if (!HRST) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      grant_q <= DEF_GNT;
      mast_q  <= DEF_IDX;
      lock_q  <= 1'b0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      mast_q  <= mast_d;
      lock_q  <= lock_d;
      incr_q  <= incr_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = mast_q;
  assign HMASTLOCK = lock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with
// literal expectations plus randomized traffic against a bus model.
module tb_ahb_bus_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic       HCLK = 1'b0;
  logic       HRST;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int n_chk  = 0;
  int n_fail = 0;

  int m_own;
  bit m_burst;
  int m_rem;
  bit m_incr;
  bit m_ml;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(
    .MASTER_NUM     (N),
    .HBURST_WIDTH   (3),
    .DEFAULT_MASTER (DEF)
  ) dut (
    .HCLK      (HCLK),
    .HRST      (HRST),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input int hb);
    case (hb)
      0:       return 1;
      1:       return 0;
      2, 3:    return 4;
      4, 5:    return 8;
      default: return 16;
    endcase
  endfunction

  task automatic model_reset();
    m_own   = DEF;
    m_burst = 0;
    m_rem   = 0;
    m_incr  = 0;
    m_ml    = 0;
  endtask

  // Bus-level view: who owns the bus, how many beats remain.
  task automatic model_step();
    bit acc;
    bit dec;
    bit keep;
    bit found;
    int nxt;
    acc = HREADY && (HTRANS == 2 || HTRANS == 3);
    dec = 0;
    if (m_burst) begin
      m_incr = 0;
      if (acc) begin
        m_rem--;
        if (m_rem <= 0) begin
          m_burst = 0;
          dec     = 1;
        end
      end else if (HREADY && HTRANS == 0) begin
        m_burst = 0;
      end
    end else if (HREADY) begin
      if (HTRANS == 2) m_incr = (HBURST == 1);
      else if (HTRANS == 0) m_incr = 0;
      if (acc && HTRANS == 2 && beats_of(int'(HBURST)) > 1) begin
        m_burst = 1;
        m_rem   = beats_of(int'(HBURST)) - 1;
      end else begin
        dec = 1;
      end
    end
    m_incr = m_incr && HBUSREQ[m_own];
    if (dec) begin
      keep = m_incr;
`ifdef AHB_ARB_LOCK_EN
      keep = keep || HLOCK[m_own] || m_ml;
`endif
      nxt = DEF;
      if (keep) begin
        nxt = m_own;
      end else begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && HBUSREQ[(m_own + k) % N]) begin
            found = 1;
            nxt   = (m_own + k) % N;
          end
        end
      end
      m_own = nxt;
`ifdef AHB_ARB_LOCK_EN
      m_ml = HLOCK[nxt];
`else
      m_ml = 0;
`endif
    end
  endtask

  always @(negedge HCLK) begin
    chk("hgrant", 32'(HGRANT), 32'(1) << m_own);
    chk("hmaster", 32'(HMASTER), 32'(m_own));
    chk("hmastlock", 32'(HMASTLOCK), 32'(m_ml));
  end

  task automatic tick();
    @(posedge HCLK);
    if (HRST) model_step();
    #1;
  endtask

  task automatic drive(input logic [3:0] req,
                       input logic [1:0] tr,
                       input logic [2:0] hb,
                       input logic       rdy,
                       input logic [3:0] lk);
    HBUSREQ = req;
    HTRANS  = tr;
    HBURST  = hb;
    HREADY  = rdy;
    HLOCK   = lk;
  endtask

  task automatic reset_now(input string nm);
    HRST = 1'b0;
    model_reset();
    #1;
    chk({nm, "_hgrant"}, 32'(HGRANT), 32'h1);
    chk({nm, "_hmaster"}, 32'(HMASTER), 32'h0);
    chk({nm, "_hmastlock"}, 32'(HMASTLOCK), 32'h0);
  endtask

  int rr_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    HRST = 1'b0;
    drive(4'b0000, 2'd0, 3'd0, 1'b1, 4'b0000);
    model_reset();
    repeat (2) tick();
    chk("rst_hgrant", 32'(HGRANT), 32'h1);
    chk("rst_hmaster", 32'(HMASTER), 32'h0);
    chk("rst_hmastlock", 32'(HMASTLOCK), 32'h0);
    HRST = 1'b1;

    drive(4'b1111, 2'd2, 3'd0, 1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_master", 32'(HMASTER), 32'(rr_exp[i]));
    end

    drive(4'b0100, 2'd0, 3'd0, 1'b1, 4'b0000);
    tick();
    chk("incr4_own_m2", 32'(HMASTER), 32'd2);
    drive(4'b0110, 2'd2, 3'd3, 1'b1, 4'b0000);
    tick();
    chk("incr4_beat1", 32'(HMASTER), 32'd2);
    HTRANS = 2'd3;
    tick();
    tick();
    chk("incr4_beat3", 32'(HMASTER), 32'd2);
    tick();
    chk("incr4_handover", 32'(HGRANT), 32'h2);

    drive(4'b0011, 2'd2, 3'd5, 1'b1, 4'b0000);
    tick();
    HTRANS = 2'd3;
    repeat (2) tick();
    HREADY = 1'b0;
    repeat (3) tick();
    chk("incr8_wait_hold", 32'(HMASTER), 32'd1);
    HREADY = 1'b1;
    repeat (4) tick();
    chk("incr8_beat7", 32'(HMASTER), 32'd1);
    tick();
    chk("incr8_handover", 32'(HMASTER), 32'd0);

    drive(4'b1001, 2'd2, 3'd7, 1'b1, 4'b0000);
    tick();
    HTRANS = 2'd3;
    tick();
    HTRANS = 2'd0;
    tick();
    chk("early_term_hold", 32'(HMASTER), 32'd0);
    tick();
    chk("early_term_m3", 32'(HGRANT), 32'h8);

    drive(4'b1001, 2'd2, 3'd3, 1'b1, 4'b0000);
    tick();
    HTRANS = 2'd3;
    tick();
    reset_now("midburst_rst");
    repeat (2) tick();
    HRST = 1'b1;
    drive(4'b0000, 2'd0, 3'd0, 1'b1, 4'b0000);

`ifdef AHB_ARB_LOCK_EN
    drive(4'b0011, 2'd2, 3'd0, 1'b1, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lock_master", 32'(HMASTER), 32'd0);
      chk("lock_mastlock", 32'(HMASTLOCK), 32'd1);
    end
    HLOCK = 4'b0000;
    tick();
    chk("lock_extra_master", 32'(HMASTER), 32'd0);
    chk("lock_extra_mastlock", 32'(HMASTLOCK), 32'd0);
    tick();
    chk("lock_release_m1", 32'(HMASTER), 32'd1);
`else
    drive(4'b0011, 2'd2, 3'd0, 1'b1, 4'b0001);
    tick();
    chk("nolock_master", 32'(HMASTER), 32'd1);
    chk("nolock_mastlock", 32'(HMASTLOCK), 32'd0);
`endif

    for (int c = 0; c < 3000; c++) begin
      logic [3:0] lk;
      for (int b = 0; b < 4; b++) lk[b] = ($urandom_range(0, 5) == 0);
      drive(4'($urandom), 2'($urandom), 3'($urandom),
            ($urandom_range(0, 3) != 0), lk);
      if ($urandom_range(0, 599) == 0) begin
        reset_now("rand_rst");
        tick();
        HRST = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
